// File: rtl/mmio_peripheral.sv
// mmio_peripheral: memory-mapped peripheral window beside the data memory.
// Provides a reload timer with interrupt, an LED register, a 7-segment digit
// register and (optionally) a free-running SYSTICK cycle counter.
// Optional feature macro: MMIO_SYSTICK_EN (SYSTICK counter present when defined).
// Bus handshake: there is no valid/ready pair; a transfer happens in the cycle
// its strobe is high while Sel is high. MemWrite commits at the rising edge,
// while MemRead is answered combinationally in the same cycle.
module mmio_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        Sel,
  output logic [31:0] Read_data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digi
);

  // Word offsets inside the 32-byte window.
  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LEDS = 3'd3;
  localparam logic [2:0] OFF_DIGI = 3'd4;
`ifdef MMIO_SYSTICK_EN
  localparam logic [2:0] OFF_TICK = 3'd5;
`endif

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  leds_q, leds_d;
  logic [11:0] digi_q, digi_d;
`ifdef MMIO_SYSTICK_EN
  logic [31:0] systick_q, systick_d;
`endif

  logic [2:0] offset;
  logic       wr_en;
  logic       wr_th, wr_tl, wr_tcon, wr_leds, wr_digi;
  logic       ovf;
  logic       ovf_set;
  logic       unused_addr_bits;

  // Byte-lane bits carry no meaning for word registers.
  assign unused_addr_bits = ^Address[1:0];

  assign Sel    = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset = Address[4:2];
  assign wr_en  = MemWrite & Sel;

  assign wr_th   = wr_en && (offset == OFF_TH);
  assign wr_tl   = wr_en && (offset == OFF_TL);
  assign wr_tcon = wr_en && (offset == OFF_TCON);
  assign wr_leds = wr_en && (offset == OFF_LEDS);
  assign wr_digi = wr_en && (offset == OFF_DIGI);

  // Overflow is a tick at the terminal count. A CPU write to TL in the same
  // cycle suppresses both the reload and the status set; the status set uses
  // the pre-write irq-enable so a concurrent TCON write cannot drop it.
  assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set = ovf && tcon_q[1] && !wr_tl;

  // Next-state for all registers: CPU writes take priority over the timer.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = {tcon_q[2] | ovf_set, tcon_q[1:0]};
    leds_d = leds_q;
    digi_d = digi_q;

    if (wr_th) th_d = Write_data;

    if (wr_tl) begin
      tl_d = Write_data;
    end else if (tcon_q[0]) begin
      tl_d = ovf ? th_q : (tl_q + 32'd1);
    end

    if (wr_tcon) tcon_d = {Write_data[2] | ovf_set, Write_data[1:0]};
    if (wr_leds) leds_d = Write_data[7:0];
    if (wr_digi) digi_d = Write_data[11:0];
  end

`ifdef MMIO_SYSTICK_EN
  // Free-running cycle counter; wraps naturally and ignores writes.
  always_comb begin
    systick_d = systick_q + 32'd1;
  end
`endif

  // Register bank with synchronous reset overriding every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'd0;
      leds_q <= 8'd0;
      digi_q <= 12'd0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      leds_q <= leds_d;
      digi_q <= digi_d;
    end
  end

`ifdef MMIO_SYSTICK_EN
  // SYSTICK register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) systick_q <= 32'd0;
    else       systick_q <= systick_d;
  end
`endif

  // Combinational read-back; returns pre-write values when a store coincides.
  always_comb begin
    Read_data = 32'd0;
    if (MemRead && Sel) begin
      case (offset)
        OFF_TH:   Read_data = th_q;
        OFF_TL:   Read_data = tl_q;
        OFF_TCON: Read_data = {29'd0, tcon_q};
        OFF_LEDS: Read_data = {24'd0, leds_q};
        OFF_DIGI: Read_data = {20'd0, digi_q};
`ifdef MMIO_SYSTICK_EN
        OFF_TICK: Read_data = systick_q;
`endif
        default:  Read_data = 32'd0;
      endcase
    end
  end

  assign irq  = tcon_q[1] & tcon_q[2];
  assign leds = leds_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral: directed scoreboard bench for mmio_peripheral.
module tb_mmio_peripheral;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LEDS = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;
  localparam logic [31:0] A_R18  = 32'h4000_0018;
  localparam logic [31:0] A_R1C  = 32'h4000_001C;

  localparam logic [2:0] K_RD   = 3'd0;
  localparam logic [2:0] K_SEL  = 3'd1;
  localparam logic [2:0] K_IRQ  = 3'd2;
  localparam logic [2:0] K_LEDS = 3'd3;
  localparam logic [2:0] K_DIGI = 3'd4;

`ifdef MMIO_SYSTICK_EN
  localparam bit TICK_EN = 1'b1;
`else
  localparam bit TICK_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic        Sel;
  logic [31:0] Read_data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digi;

  logic        chk_valid;
  logic [31:0] tick_m;
  logic [34:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  mmio_peripheral dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Sel        (Sel),
    .Read_data  (Read_data),
    .irq        (irq),
    .leds       (leds),
    .digi       (digi)
  );

  // Clock and reset-free state
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the cycle counter: cleared by reset, +1 every edge.
  always @(posedge clk) begin
    if (reset) tick_m <= 32'd0;
    else       tick_m <= tick_m + 32'd1;
  end

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_RD:    return "read_data";
      K_SEL:   return "sel";
      K_IRQ:   return "irq";
      K_LEDS:  return "leds";
      default: return "digi";
    endcase
  endfunction

  // Monitor: mid-cycle, pop every expectation issued for this cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      while (exp_q.size() > 0) begin
        logic [34:0] ent;
        logic [31:0] act;
        ent = exp_q.pop_front();
        case (ent[34:32])
          K_RD:    act = Read_data;
          K_SEL:   act = {31'd0, Sel};
          K_IRQ:   act = {31'd0, irq};
          K_LEDS:  act = {24'd0, leds};
          default: act = {20'd0, digi};
        endcase
        n_tests++;
        if (act !== ent[31:0]) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (t=%0t)", kname(ent[34:32]), act, ent[31:0], $time);
        end
      end
    end
  end

  // Driver tasks
  task automatic expect_v(input logic [2:0] k, input logic [31:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic step();
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
  endtask

  task automatic set_rd(input logic [31:0] a);
    Address  = a;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] v);
    set_rd(a);
    expect_v(K_RD, v);
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    MemRead    = 1'b0;
    step();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    n_tests = 0; n_fail = 0;
    chk_valid = 1'b0;
    reset = 1'b1; Address = 32'd0; Write_data = 32'd0;
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    set_rd(A_TH); expect_v(K_RD, 32'd0); expect_v(K_SEL, 32'd1);
    expect_v(K_IRQ, 32'd0); expect_v(K_LEDS, 32'd0); expect_v(K_DIGI, 32'd0);
    step();
    rd_chk(A_TL, 32'd0);
    rd_chk(A_TCON, 32'd0);
    rd_chk(A_LEDS, 32'd0);
    rd_chk(A_DIGI, 32'd0);
    rd_chk(A_TICK, TICK_EN ? tick_m : 32'd0);
    rd_chk(A_R18, 32'd0);
    rd_chk(A_R1C, 32'd0);

    // Register write / readback with truncation
    wr(A_LEDS, 32'h0000_01A5);
    set_rd(A_LEDS); expect_v(K_RD, 32'hA5); expect_v(K_LEDS, 32'hA5); step();
    wr(A_DIGI, 32'hFFFF_FABC);
    set_rd(A_DIGI); expect_v(K_RD, 32'hABC); expect_v(K_DIGI, 32'hABC); step();

    // Timer reload and interrupt
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'd3);
    set_rd(A_TL); expect_v(K_RD, 32'hFFFF_FFFD); expect_v(K_IRQ, 32'd0); step();
    set_rd(A_TL); expect_v(K_RD, 32'hFFFF_FFFE); expect_v(K_IRQ, 32'd0); step();
    set_rd(A_TL); expect_v(K_RD, 32'hFFFF_FFFF); expect_v(K_IRQ, 32'd0); step();
    set_rd(A_TL); expect_v(K_RD, 32'hFFFF_FFFD); expect_v(K_IRQ, 32'd1); step();
    wr(A_TCON, 32'd3);
    set_rd(A_TCON); expect_v(K_RD, 32'd3); expect_v(K_IRQ, 32'd0); step();
    wr(A_TCON, 32'd0);
    set_rd(A_TCON); expect_v(K_RD, 32'd0); expect_v(K_IRQ, 32'd0); step();

    // Collision: TL write beats overflow, no status set
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TL, 32'd5);
    rd_chk(A_TL, 32'd5);
    set_rd(A_TCON); expect_v(K_RD, 32'd3); expect_v(K_IRQ, 32'd0); step();
    wr(A_TCON, 32'd0);

    // Collision: TCON write during overflow keeps the status
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TCON, 32'd3);
    set_rd(A_TCON); expect_v(K_RD, 32'd7); expect_v(K_IRQ, 32'd1); step();
    wr(A_TCON, 32'd0);
    set_rd(A_TCON); expect_v(K_RD, 32'd0); expect_v(K_IRQ, 32'd0); step();

    // Collision: irq-enable cleared during overflow, status still latched
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TCON, 32'd1);
    set_rd(A_TCON); expect_v(K_RD, 32'd5); expect_v(K_IRQ, 32'd0); step();
    wr(A_TCON, 32'd0);

    // Decode
    set_rd(32'h4000_0020); expect_v(K_RD, 32'd0); expect_v(K_SEL, 32'd0); step();
    set_rd(32'h3FFF_FFFC); expect_v(K_RD, 32'd0); expect_v(K_SEL, 32'd0); step();
    wr(A_R18, 32'hFFFF_FFFF);
    wr(32'h4000_002C, 32'hFFFF_FFFF);
    rd_chk(A_R18, 32'd0);
    set_rd(A_TH); expect_v(K_RD, 32'hFFFF_FFFD);
    expect_v(K_LEDS, 32'hA5); expect_v(K_DIGI, 32'hABC); step();

    // Simultaneous read and write shows the pre-write value
    Address = A_LEDS; Write_data = 32'h3C; MemRead = 1'b1; MemWrite = 1'b1;
    expect_v(K_RD, 32'hA5); step();
    set_rd(A_LEDS); expect_v(K_RD, 32'h3C); expect_v(K_LEDS, 32'h3C); step();

    // SYSTICK tracking and write-ignore
    rd_chk(A_TICK, TICK_EN ? tick_m : 32'd0);
    repeat (9) step();
    rd_chk(A_TICK, TICK_EN ? tick_m : 32'd0);
    wr(A_TICK, 32'd0);
    rd_chk(A_TICK, TICK_EN ? tick_m : 32'd0);

    // Reset mid-count overrides a concurrent write
    wr(A_TL, 32'h100);
    wr(A_TCON, 32'd3);
    Address = A_LEDS; Write_data = 32'hFF; MemWrite = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    set_rd(A_TL); expect_v(K_RD, 32'd0); expect_v(K_LEDS, 32'd0);
    expect_v(K_DIGI, 32'd0); expect_v(K_IRQ, 32'd0); step();
    rd_chk(A_TCON, 32'd0);
    rd_chk(A_TICK, TICK_EN ? tick_m : 32'd0);

    // Drain: every issued expectation must have been consumed.
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_peripheral.md
# mmio_peripheral

Memory-mapped peripheral block sitting beside the data memory, downstream of the single-cycle CPU datapath. It consumes the ALU result as the bus address, plus rt read data, MemRead and MemWrite. It decodes the window 0x4000_0000–0x4000_001F and provides a reload timer with interrupt, an LED register, a 7-segment digit register and a free-running cycle counter. Reads are combinational so a `lw` completes in one cycle; all register updates occur on the rising clock edge.

## Interface
- `BASE_ADDR`, 32'h4000_0000, base of the 32-byte peripheral window (32-byte aligned).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Address`  in  32  byte address from the ALU output; bits [1:0] ignored.
- `Write_data`  in  32  store data (rt read data).
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `Sel`  out  1  combinational: `Address[31:5] == BASE_ADDR[31:5]`; steers the CPU's read-back mux away from data memory.
- `Read_data`  out  32  combinational read data.
- `irq`  out  1  timer interrupt request.
- `leds`  out  8  LED register.
- `digi`  out  12  {an[3:0], seg[7:0]} 7-segment register.

## Operation
- Register map, by word offset:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: count, R/W.
  - 0x08 TCON[2:0], R/W: bit0 = enable, bit1 = irq enable, bit2 = status.
  - 0x0C LEDS[7:0], R/W.
  - 0x10 DIGI[11:0], R/W.
  - 0x14 SYSTICK, read-only.
  - 0x18 and 0x1C: read 0; writes ignored.
- Write: when `MemWrite & Sel`, the addressed register takes `Write_data` (truncated to the register width) at the clock edge.
- Read: when `MemRead & Sel`, `Read_data` is the addressed register, zero-extended. Otherwise `Read_data` = 0.
- Timer, when TCON[0] = 1, each cycle:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and TCON[2] is set if TCON[1] = 1.
  - Else: TL <= TL + 1.
- Timer, when TCON[0] = 0: TL holds.
- `irq` = TCON[1] & TCON[2]. It is registered-state derived, with no combinational path from the bus.
- SYSTICK: increments every cycle; wraps 32'hFFFF_FFFF -> 0. Writes to it are ignored.

## Timing
- Reset (sync): TH, TL, TCON, LEDS, DIGI, SYSTICK all 0. Consequently `irq` = 0, `leds` = 0, `digi` = 0 in the cycle after reset is sampled high.
- Reset asserted mid-count overrides every other event in that cycle.
- Write latency: the new value is visible on `Read_data` and the outputs in the cycle after the write edge.
- Read latency: 0 cycles (combinational).
- Simultaneous CPU write to TL and timer tick/overflow: the CPU write wins; there is no reload and no increment that cycle.
- Overflow does not set status in a cycle where TL is written.
- Simultaneous CPU write to TCON and overflow: TCON <= {Write_data[2] | ovf_set, Write_data[1:0]}, where ovf_set uses the pre-write TCON[1]. An interrupt is never lost.
- Interrupt clear: software writes TCON[2] = 0, taking effect the next cycle if no overflow occurs in the same cycle.
- TH == 32'hFFFF_FFFF: overflow fires every enabled cycle.
- `MemRead` and `MemWrite` both high: the write occurs, and `Read_data` shows the pre-write value.

## Configuration
- `MMIO_SYSTICK_EN` defined: SYSTICK counter is present as above.
- Not defined: no SYSTICK flip-flops; offset 0x14 reads 0 and writes are ignored.

## Test plan
- Reset and reads:
  - Stimulus: hold `reset` 2 cycles, then read every offset.
  - Response: all reads 0, `irq` = 0, `leds` = 0, `digi` = 0.
- Register write / readback:
  - Stimulus: write 0x1A5 to 0x4000_000C and 0xABC to 0x4000_0010.
  - Response: next cycle `leds` = 0xA5, `digi` = 0xABC, and readback matches the truncated values.
- Timer reload and interrupt:
  - Stimulus: TH = 0xFFFF_FFFD, TL = 0xFFFF_FFFD, TCON = 3.
  - Response:
    - TL steps FFFE, FFFF, then reloads to FFFD on the third cycle.
    - `irq` rises in the cycle after the reload edge.
  - Stimulus: write TCON = 3.
  - Response: `irq` drops.
- Write vs. overflow collision:
  - Stimulus: TCON = 3, TL = 0xFFFF_FFFF, and in the same cycle write TL = 5.
  - Response: TL = 5 and TCON[2] stays 0.
  - Stimulus: repeat with a TCON write of 3 in the overflow cycle.
  - Response: TCON[2] = 1.
- Decode:
  - Stimulus: read 0x4000_0020 and 0x3FFF_FFFC.
  - Response: `Sel` = 0 and `Read_data` = 0; a write to 0x4000_0018 changes no register.
- SYSTICK:
  - With `MMIO_SYSTICK_EN`: reading 0x4000_0014 at cycle N and again at N+10 differs by exactly 10; a write of 0 is ignored.
  - Without the macro: reads return 0.
